// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator display path
package calc_pkg;

  localparam int BIN_W       = 14;
  localparam int BCD_DIGITS  = 4;
  localparam int MAX_DISPLAY = 9999;
  localparam int SCRATCH_W   = 4 * (BCD_DIGITS + 1);
  localparam int CNT_W       = 4;

  typedef logic [3:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } bin2bcd_state_t;

  // Elaboration-time decimal to packed BCD, used for the saturation pattern.
  function automatic logic [4*BCD_DIGITS-1:0] to_bcd(input int unsigned v);
    logic [4*BCD_DIGITS-1:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [4*BCD_DIGITS-1:0] MAX_BCD = to_bcd(MAX_DISPLAY);

endpackage

// File: rtl/bin2bcd_seq_if.sv
// rtl/bin2bcd_seq_if.sv - request/result bundle between calculator core and BCD converter
interface bin2bcd_seq_if;
  import calc_pkg::*;

  logic             start;
  logic [BIN_W-1:0] bin_i;
  logic             busy;
  logic             done;
  bcd_digit_t       digit_0;
  bcd_digit_t       digit_1;
  bcd_digit_t       digit_2;
  bcd_digit_t       digit_3;
  logic             overflow;

  modport master (
    output start, bin_i,
    input  busy, done, digit_0, digit_1, digit_2, digit_3, overflow
  );

  modport slave (
    input  start, bin_i,
    output busy, done, digit_0, digit_1, digit_2, digit_3, overflow
  );

endinterface

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble correction cell: add 3 when the nibble is 5 or more
module bcd_add3
  import calc_pkg::*;
(
  input  bcd_digit_t nibble_i,
  output bcd_digit_t nibble_o
);

  assign nibble_o = (nibble_i >= 4'd5) ? nibble_i + 4'd3 : nibble_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential 14-bit binary to 4-digit BCD converter, one bit per clock
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  bin2bcd_seq_if.slave  bus
);

  bin2bcd_state_t            state_q, state_d;
  logic [BIN_W-1:0]          bin_q, bin_d;
  logic [SCRATCH_W-1:0]      scratch_q, scratch_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [4*BCD_DIGITS-1:0]   digits_q, digits_d;
  logic                      ovf_q, ovf_d;
  logic                      done_q, done_d;
  logic [SCRATCH_W-1:0]      adj;
  logic                      ovf_now;

  // Correction is applied to every nibble of the current scratch before the shift.
  for (genvar g = 0; g < BCD_DIGITS + 1; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble_i (scratch_q[4*g +: 4]),
      .nibble_o (adj[4*g +: 4])
    );
  end

  assign ovf_now = |scratch_q[SCRATCH_W-1 -: 4];

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    digits_d  = digits_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = SHIFT;
          bin_d     = bus.bin_i;
          scratch_d = '0;
          cnt_d     = '0;
        end
      end
      SHIFT: begin
        scratch_d = SCRATCH_W'({adj, bin_q[BIN_W-1]});
        bin_d     = {bin_q[BIN_W-2:0], 1'b0};
        cnt_d     = cnt_q + 4'd1;
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        ovf_d    = ovf_now;
        digits_d = (SATURATE && ovf_now) ? MAX_BCD : scratch_q[4*BCD_DIGITS-1:0];
        done_d   = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = done_q;
  assign bus.overflow = ovf_q;
  assign bus.digit_0  = digits_q[3:0];
  assign bus.digit_1  = digits_q[7:4];
  assign bus.digit_2  = digits_q[11:8];
  assign bus.digit_3  = digits_q[15:12];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq, saturating and wrapping builds side by side
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [16:0] q_sat[$];
  logic [16:0] q_wrap[$];
  logic [16:0] last_sat  = '0;
  logic [16:0] last_wrap = '0;

  always #5 clk = ~clk;

  bin2bcd_seq_if if_sat ();
  bin2bcd_seq_if if_wrap ();

  bin2bcd_seq #(.SATURATE(1'b1)) u_sat (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if_sat)
  );

  bin2bcd_seq #(.SATURATE(1'b0)) u_wrap (
    .clk   (clk),
    .reset (rst_n),
    .bus   (if_wrap)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [16:0] model(input int v, input bit sat);
    int  d;
    logic ovf;
    ovf = (v > 9999);
    d   = (sat && ovf) ? 9999 : (v % 10000);
    return {ovf, 4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
  endfunction

  function automatic logic [16:0] pack_sat();
    return {if_sat.overflow, if_sat.digit_3, if_sat.digit_2, if_sat.digit_1, if_sat.digit_0};
  endfunction

  function automatic logic [16:0] pack_wrap();
    return {if_wrap.overflow, if_wrap.digit_3, if_wrap.digit_2, if_wrap.digit_1, if_wrap.digit_0};
  endfunction

  // Monitors: pop on every done pulse, otherwise the outputs must hold.
  always @(negedge clk) begin
    logic [16:0] cur;
    if (!rst_n) begin
      last_sat = '0;
    end else begin
      cur = pack_sat();
      if (if_sat.done) begin
        if (q_sat.size() == 0) chk("sat_unexpected_done", 32'(cur), 32'h1ffff);
        else chk("sat_result", 32'(cur), 32'(q_sat.pop_front()));
        last_sat = cur;
      end else begin
        chk("sat_hold", 32'(cur), 32'(last_sat));
      end
    end
  end

  always @(negedge clk) begin
    logic [16:0] cur;
    if (!rst_n) begin
      last_wrap = '0;
    end else begin
      cur = pack_wrap();
      if (if_wrap.done) begin
        if (q_wrap.size() == 0) chk("wrap_unexpected_done", 32'(cur), 32'h1ffff);
        else chk("wrap_result", 32'(cur), 32'(q_wrap.pop_front()));
        last_wrap = cur;
      end else begin
        chk("wrap_hold", 32'(cur), 32'(last_wrap));
      end
    end
  end

  task automatic drive(input logic s, input logic [13:0] b);
    if_sat.start  = s;
    if_wrap.start = s;
    if_sat.bin_i  = b;
    if_wrap.bin_i = b;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_sat_out"},  32'({if_sat.busy, if_sat.done, pack_sat()}), 32'h0);
    chk({tag, "_wrap_out"}, 32'({if_wrap.busy, if_wrap.done, pack_wrap()}), 32'h0);
  endtask

  // One conversion; kick>0 re-asserts start with 42 during that SHIFT cycle.
  task automatic issue(input int v, input logic [16:0] e_sat, input logic [16:0] e_wrap,
                       input bit chk_lat, input int kick);
    int lat;
    int bcnt;
    @(posedge clk); #1;
    drive(1'b1, 14'(v));
    q_sat.push_back(e_sat);
    q_wrap.push_back(e_wrap);
    @(posedge clk); #1;
    drive(1'b0, 14'(v));
    lat  = 0;
    bcnt = if_sat.busy ? 1 : 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == kick) drive(1'b1, 14'd42);
      else drive(1'b0, 14'd42);
      if (if_sat.busy) bcnt++;
      if (if_sat.done) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) chk("done_timeout", 32'(lat), 32'd15);
    else if (chk_lat) begin
      chk("latency", 32'(lat), 32'd15);
      chk("busy_cycles", 32'(bcnt), 32'd15);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 14'd0);
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    rst_n = 1'b1;

    issue(1234,  17'h0_1234, 17'h0_1234, 1'b1, 0);
    issue(0,     17'h0_0000, 17'h0_0000, 1'b1, 0);
    issue(9999,  17'h0_9999, 17'h0_9999, 1'b1, 0);
    issue(12345, 17'h1_9999, 17'h1_2345, 1'b1, 0);
    issue(16383, 17'h1_9999, 17'h1_6383, 1'b0, 0);
    issue(10000, 17'h1_9999, 17'h1_0000, 1'b0, 0);
    issue(5678,  17'h0_5678, 17'h0_5678, 1'b1, 5);
    repeat (20) @(posedge clk);
    #1;
    chk("no_second_run_busy", 32'(if_sat.busy), 32'd0);

    // Reset in the middle of a conversion of 4321.
    @(posedge clk); #1;
    drive(1'b1, 14'd4321);
    @(posedge clk); #1;
    drive(1'b0, 14'd0);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_idle_zero("abort");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_idle_zero("after_abort");

    issue(1234, 17'h0_1234, 17'h0_1234, 1'b1, 0);

    for (int v = 0; v < 16384; v += 7) begin
      issue(v, model(v, 1'b1), model(v, 1'b0), 1'b0, 0);
    end

    repeat (4) @(posedge clk);
    chk("sat_queue_empty",  32'(q_sat.size()),  32'd0);
    chk("wrap_queue_empty", 32'(q_wrap.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
